// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving the select of a WIDTH-bit 2:1 mux array.
// Grants, select and output data are registered; ownership is bounded by MAX_HOLD.
module mux2_arbiter #(
  parameter int WIDTH    = 16,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             done0,
  input  logic             done1,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam bit         PREEMPT   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [7:0] r_hold;
  logic       r_last;

  logic             w_own_req;
  logic             w_oth_req;
  logic             w_own_done;
  logic             w_release;
  logic             w_xfer;
  logic             w_pick0;
  logic [WIDTH-1:0] w_mux;

  assign w_own_req  = (r_state == OWN0) ? req0  : req1;
  assign w_oth_req  = (r_state == OWN0) ? req1  : req0;
  assign w_own_done = (r_state == OWN0) ? done0 : done1;

  // The owner lets go on done, on dropping its request, or when its hold budget runs out
  // while the other side is waiting.
  assign w_release = (r_state != IDLE) &&
                     (w_own_done || !w_own_req ||
                      (PREEMPT && (r_hold == HOLD_LAST) && w_oth_req));

  assign w_xfer  = (gnt0 & req0) | (gnt1 & req1);
  // r_last == 1 means requester 1 was served most recently, so requester 0 wins a tie.
  assign w_pick0 = req0 && (!req1 || r_last);
  assign w_mux   = sel ? in0 : in1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_hold    <= 8'd0;
      r_last    <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      sel       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= w_xfer;
      if (w_xfer) begin
        out_data <= w_mux;
      end

      case (r_state)
        IDLE: begin
          if (req0 || req1) begin
            r_hold <= 8'd0;
            if (w_pick0) begin
              r_state <= OWN0;
              gnt0    <= 1'b1;
              sel     <= 1'b1;
            end else begin
              r_state <= OWN1;
              gnt1    <= 1'b1;
              sel     <= 1'b0;
            end
          end
        end

        OWN0: begin
          if (w_release) begin
            r_last <= 1'b0;
            gnt0   <= 1'b0;
            if (req1) begin
              r_state <= OWN1;
              r_hold  <= 8'd0;
              gnt1    <= 1'b1;
              sel     <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end

        OWN1: begin
          if (w_release) begin
            r_last <= 1'b1;
            gnt1   <= 1'b0;
            if (req0) begin
              r_state <= OWN0;
              r_hold  <= 8'd0;
              gnt0    <= 1'b1;
              sel     <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_hold != 8'hFF) begin
            r_hold <= r_hold + 8'd1;
          end
        end

        default: begin
          r_state <= IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
        end
      endcase
    end
  end

endmodule
